i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Transmit half of the WM8731 I2S link. It serialises 16-bit playback samples onto AUD_DACDAT in I2S slave mode; the codec masters AUD_BCLK and AUD_DACLRCK.
- It pulls samples from the SRAM/playback path with a request/valid handshake, one sample per LRCK frame, and sends each sample mono-duplicated to the left and right channels.
- It sits beside the ADC capture path inside the I2S block.
- It is active only while the top FSM is in a PLAY state.

Parameters:
- DATA_W, 16, sample width and bits shifted per channel.
- SYNC_STAGES, 2, flip-flop synchroniser depth for AUD_BCLK and AUD_DACLRCK (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  high while the top state is PLAY_PLAY.
- aud_bclk  in  1  codec bit clock, asynchronous to clk.
- aud_daclrck  in  1  codec DAC word clock, asynchronous; low = left channel.
- play_data  in  DATA_W  sample from the playback path; two's complement.
- play_valid  in  1  one-cycle strobe qualifying play_data.
- request_play_data  out  1  one-cycle pulse asking for the next sample.
- aud_dacdat  out  1  serial data to the codec.
- underrun  out  1  one-cycle pulse: no sample was ready at a frame start.

Behaviour:
Reset and enable:
- rst high: all outputs 0, state IDLE, holding register cleared, hold_full 0, req_pending 0, synchronisers cleared.
- The prime frame is the first frame after entering RUN.

Synchronisation and edge detection:
- aud_bclk and aud_daclrck each pass through SYNC_STAGES flops, sampled in the same clk cycle so their relative ordering is preserved.
- bclk_fall = synced BCLK 1->0. lr_fall = synced LRCK 1->0 (left start). lr_rise = synced LRCK 0->1 (right start).
- End-to-end latency from a pin edge to an aud_dacdat change is at most SYNC_STAGES+2 clk cycles.

FSM:
- IDLE: aud_dacdat=0; no requests. Go to ARM when enable=1.
- ARM: wait for lr_fall. Then pulse request_play_data, set req_pending, load the shift register with 0 (prime frame sends silence), set bitcnt=DATA_W, and go to RUN.
- RUN: actions by event:
  - lr_fall: pulse request_play_data and set req_pending. If hold_full, cur_sample<=hold, hold_full<=0; else pulse underrun and cur_sample<=0. Load the shift register from the new cur_sample and set bitcnt=DATA_W.
  - lr_rise: load the shift register from cur_sample (right channel = same sample) and set bitcnt=DATA_W.
  - bclk_fall with bitcnt>0: aud_dacdat<=sreg[MSB], shift left, bitcnt-1.
  - bclk_fall with bitcnt=0: aud_dacdat<=0.
  - The MSB therefore goes out on the first BCLK falling edge after the LRCK transition; the codec samples it on the following rising edge, giving the standard 1-bit I2S delay.
- enable falling in any state: go to IDLE next cycle. aud_dacdat<=0, hold_full and req_pending cleared. A mid-frame abort is legal and yields a truncated word.

Handshake:
- play_valid is accepted only when req_pending=1. On accept: hold<=play_data, hold_full<=1, req_pending<=0.
- play_valid with req_pending=0 is ignored.
- A response may arrive any number of cycles later, up to the next lr_fall. A late response counts as an underrun for that frame and is stored for the following frame.
- play_valid in the same cycle as lr_fall: the request pulse of that cycle sets req_pending, and the sample is consumed by the current frame (bypass into cur_sample); no underrun.

Simultaneous events:
- If lr_fall/lr_rise and bclk_fall coincide, the load takes priority and the bit is driven on the next bclk_fall.
- The request pulse is never repeated within a frame.

Optional Feature:
- Macro DAC_HOLD_LAST_EN.
- Defined: on underrun, cur_sample keeps its previous value (repeat last sample); the underrun pulse still fires.
- Undefined: on underrun, cur_sample<=0 (silence).

Test Plan:
- Reset: rst=1 for 3 cycles with toggling BCLK -> aud_dacdat=0, request_play_data=0, underrun=0 throughout.
- Basic frame:
  - Stimulus: enable=1, BCLK 3.072 MHz, LRCK 48 kHz; answer each request 4 cycles later with 0xA5C3.
  - Response: prime frame all zeros. Next frame, left and right each carry bits 1010010111000011 MSB-first, starting on the first BCLK fall after each LRCK edge, then zeros to the end of the half-frame.
  - Exactly one request per frame.
- Underrun: withhold play_valid for one frame -> one underrun pulse at the next lr_fall, both channels 0x0000 (0x1234 repeated with DAC_HOLD_LAST_EN after a prior 0x1234). A late 0x5555 then plays in the following frame.
- Unsolicited valid: play_valid with 0xFFFF while req_pending=0 -> ignored; the next word sent matches the requested sample.
- Abort: drop enable at bit 7 of the left word -> aud_dacdat=0 from the next cycle. Re-enable -> ARM waits for lr_fall, and a silent prime frame is sent before data.
- Coincident edges: place lr_fall and bclk_fall in the same synced cycle, with play_valid returning 0x8001 in that same cycle -> no underrun, MSB=1 driven on the next bclk_fall, word 0x8001.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
// -----------------------------------------------------------------------------
// Transmit half of the WM8731 I2S link, codec in master mode (it drives
// AUD_BCLK and AUD_DACLRCK). One 16-bit playback sample is fetched per LRCK
// frame through a request/valid handshake and sent mono-duplicated on the
// left and right channels, MSB first, with the standard one-bit I2S delay.
//
// Optional feature (compile-time macro DAC_HOLD_LAST_EN):
//   defined   : on underrun the previous sample is repeated
//   undefined : on underrun the frame is silent (0)
// The underrun pulse fires in both builds.
//
// Ports:
//   clk                in   system clock (50 MHz)
//   rst                in   synchronous active-high reset
//   enable             in   high while the top FSM is in PLAY_PLAY
//   aud_bclk           in   codec bit clock, asynchronous to clk
//   aud_daclrck        in   codec DAC word clock, asynchronous, low = left
//   play_data          in   [DATA_W] two's complement sample
//   play_valid         in   one-cycle strobe qualifying play_data
//   request_play_data  out  one-cycle pulse asking for the next sample
//   aud_dacdat         out  serial data to the codec
//   underrun           out  one-cycle pulse: no sample ready at frame start
// -----------------------------------------------------------------------------
module i2s_dac_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              aud_bclk,
  input  logic              aud_daclrck,
  input  logic [DATA_W-1:0] play_data,
  input  logic              play_valid,
  output logic              request_play_data,
  output logic              aud_dacdat,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bclk_sync_r;
  logic [SYNC_STAGES-1:0] lrck_sync_r;
  logic                   bclk_prev_r;
  logic                   lrck_prev_r;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_fall_s;
  logic                   lr_fall_s;
  logic                   lr_rise_s;

  // Both pins shift through their chains in the same cycle so the relative
  // order of BCLK and LRCK edges survives synchronisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_r <= {SYNC_STAGES{1'b0}};
      lrck_sync_r <= {SYNC_STAGES{1'b0}};
      bclk_prev_r <= 1'b0;
      lrck_prev_r <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], aud_daclrck};
      bclk_prev_r <= bclk_sync_r[SYNC_STAGES-1];
      lrck_prev_r <= lrck_sync_r[SYNC_STAGES-1];
    end
  end

  assign bclk_s      = bclk_sync_r[SYNC_STAGES-1];
  assign lrck_s      = lrck_sync_r[SYNC_STAGES-1];
  assign bclk_fall_s = bclk_prev_r & ~bclk_s;
  assign lr_fall_s   = lrck_prev_r & ~lrck_s;
  assign lr_rise_s   = ~lrck_prev_r & lrck_s;

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  state_t              state_r,       state_next;
  logic [DATA_W-1:0]   sreg_r,        sreg_next;
  logic [CNT_W-1:0]    bitcnt_r,      bitcnt_next;
  logic [DATA_W-1:0]   cur_sample_r,  cur_next;
  logic [DATA_W-1:0]   hold_r,        hold_next;
  logic                hold_full_r,   hold_full_next;
  logic                req_pending_r, req_pending_next;
  logic                dacdat_next;
  logic                req_next;
  logic                underrun_next;
  logic                accept_s;

  // A response is only taken while a request is outstanding.
  assign accept_s = play_valid & req_pending_r;

  // Next-state and next-datapath computation.
  always_comb begin
    state_next       = state_r;
    sreg_next        = sreg_r;
    bitcnt_next      = bitcnt_r;
    cur_next         = cur_sample_r;
    hold_next        = hold_r;
    hold_full_next   = hold_full_r;
    req_pending_next = req_pending_r;
    dacdat_next      = aud_dacdat;
    req_next         = 1'b0;
    underrun_next    = 1'b0;

    if (!enable) begin
      // Abort from any state; a word in flight is simply truncated.
      state_next       = ST_IDLE;
      dacdat_next      = 1'b0;
      hold_full_next   = 1'b0;
      req_pending_next = 1'b0;
      bitcnt_next      = ZERO_CNT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dacdat_next = 1'b0;
          state_next  = ST_ARM;
        end

        ST_ARM: begin
          dacdat_next = 1'b0;
          if (lr_fall_s) begin
            // Prime frame: ask for the first sample and send silence while
            // it is fetched.
            req_next         = 1'b1;
            req_pending_next = 1'b1;
            sreg_next        = {DATA_W{1'b0}};
            cur_next         = {DATA_W{1'b0}};
            bitcnt_next      = FULL_CNT;
            state_next       = ST_RUN;
          end else begin
            state_next = ST_ARM;
          end
        end

        ST_RUN: begin
          if (lr_fall_s) begin
            // Left channel start: pick up the fetched sample and request the
            // next one. A response arriving in this very cycle is bypassed
            // straight into the current frame.
            req_next         = 1'b1;
            req_pending_next = 1'b1;
            bitcnt_next      = FULL_CNT;
            if (hold_full_r) begin
              cur_next       = hold_r;
              sreg_next      = hold_r;
              hold_full_next = 1'b0;
            end else if (accept_s) begin
              cur_next  = play_data;
              sreg_next = play_data;
            end else begin
              underrun_next = 1'b1;
`ifdef DAC_HOLD_LAST_EN
              cur_next  = cur_sample_r;
              sreg_next = cur_sample_r;
`else
              cur_next  = {DATA_W{1'b0}};
              sreg_next = {DATA_W{1'b0}};
`endif
            end
          end else begin
            if (accept_s) begin
              hold_next        = play_data;
              hold_full_next   = 1'b1;
              req_pending_next = 1'b0;
            end else begin
              hold_next = hold_r;
            end

            // A channel load wins over a coincident BCLK fall; the MSB then
            // goes out on the next fall, giving the one-bit I2S delay.
            if (lr_rise_s) begin
              sreg_next   = cur_sample_r;
              bitcnt_next = FULL_CNT;
            end else if (bclk_fall_s) begin
              if (bitcnt_r != ZERO_CNT) begin
                dacdat_next = sreg_r[DATA_W-1];
                sreg_next   = {sreg_r[DATA_W-2:0], 1'b0};
                bitcnt_next = bitcnt_r - ONE_CNT;
              end else begin
                dacdat_next = 1'b0;
              end
            end else begin
              sreg_next = sreg_r;
            end
          end
        end

        default: begin
          state_next  = ST_IDLE;
          dacdat_next = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      sreg_r            <= {DATA_W{1'b0}};
      bitcnt_r          <= ZERO_CNT;
      cur_sample_r      <= {DATA_W{1'b0}};
      hold_r            <= {DATA_W{1'b0}};
      hold_full_r       <= 1'b0;
      req_pending_r     <= 1'b0;
      aud_dacdat        <= 1'b0;
      request_play_data <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      state_r           <= state_next;
      sreg_r            <= sreg_next;
      bitcnt_r          <= bitcnt_next;
      cur_sample_r      <= cur_next;
      hold_r            <= hold_next;
      hold_full_r       <= hold_full_next;
      req_pending_r     <= req_pending_next;
      aud_dacdat        <= dacdat_next;
      request_play_data <= req_next;
      underrun          <= underrun_next;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_dac_tx
// -----------------------------------------------------------------------------
// Scoreboard bench for i2s_dac_tx. The codec clocks are generated from clk:
// BCLK period 16 clk cycles, LRCK frame 64 BCLK (32 per channel), LRCK
// changing on BCLK falling edges. Stimulus pushes the expected word of each
// frame (twice: left, right); a monitor samples aud_dacdat at each BCLK rise,
// assembles each half-frame and pops/compares.
// -----------------------------------------------------------------------------
module tb_i2s_dac_tx;

  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME       = 1024;

`ifdef DAC_HOLD_LAST_EN
  localparam logic [15:0] UND_WORD = 16'h1234;
`else
  localparam logic [15:0] UND_WORD = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic [15:0] play_data;
  logic        play_valid;
  logic        request_play_data;
  logic        aud_dacdat;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 1022;
  int pin_ph = 0;
  bit mon_on = 1'b0;
  int req_cnt = 0;
  int und_cnt = 0;
  logic [15:0] exp_q[$];

  i2s_dac_tx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .aud_bclk          (aud_bclk),
    .aud_daclrck       (aud_daclrck),
    .play_data         (play_data),
    .play_valid        (play_valid),
    .request_play_data (request_play_data),
    .aud_dacdat        (aud_dacdat),
    .underrun          (underrun)
  );

  always #10 clk = ~clk;

  // Codec clock generator: pins change on clk falling edges.
  initial begin
    aud_bclk    = 1'b0;
    aud_daclrck = 1'b0;
    forever begin
      @(negedge clk);
      pin_ph      = cyc % FRAME;
      aud_bclk    = ((pin_ph % 16) >= 8);
      aud_daclrck = ((pin_ph / 16) >= 32);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Advance to the next frame start (LRCK falling on the pins).
  task automatic wait_frame();
    for (int i = 0; i < FRAME + 1; i++) begin
      step(1);
      if (pin_ph == 0) break;
    end
  endtask

  task automatic pulse_valid(input logic [15:0] d);
    play_data  = d;
    play_valid = 1'b1;
    step(1);
    play_valid = 1'b0;
  endtask

  // Runs one frame starting at a frame boundary and ending at the next one.
  task automatic run_frame(input bit answer, input logic [15:0] data, input int delay,
                           input bit bypass, input logic [15:0] bypass_data,
                           input bit unsolicited, input logic [15:0] exp_word,
                           input int exp_req, input int exp_und);
    int  rsnap;
    int  usnap;
    bit  seen;
    rsnap = req_cnt;
    usnap = und_cnt;
    exp_q.push_back(exp_word);
    exp_q.push_back(exp_word);
    if (bypass) begin
      // Valid lands in the cycle the synchronised LRCK fall is acted on.
      step(SYNC_STAGES);
      pulse_valid(bypass_data);
    end
    if (answer) begin
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (req_cnt != rsnap) begin
          seen = 1'b1;
          break;
        end
        step(1);
      end
      if (!seen) begin
        errors++;
        checks++;
        $display("FAIL req_timeout: got no request expected one within 100 cycles");
      end
      step(delay - 1);
      pulse_valid(data);
      if (unsolicited) begin
        step(50);
        pulse_valid(16'hFFFF);
      end
    end
    wait_frame();
    chk("req_per_frame", req_cnt - rsnap, exp_req);
    chk("underrun_count", und_cnt - usnap, exp_und);
  endtask

  // Monitor: pulse counters plus half-frame word assembly and comparison.
  initial begin
    int          s;
    bit          act;
    logic [15:0] wrd;
    logic        pad;
    logic [15:0] e;
    act = 1'b0;
    wrd = 16'h0000;
    pad = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (request_play_data === 1'b1) req_cnt++;
      if (underrun === 1'b1) und_cnt++;
      if ((pin_ph % 16) == 12) begin
        s = (pin_ph / 16) % 32;
        if (s == 0) begin
          act = mon_on;
          wrd = 16'h0000;
          pad = aud_dacdat;
        end else if (s <= 16) begin
          wrd = {wrd[14:0], aud_dacdat};
        end else begin
          pad = pad | aud_dacdat;
        end
        if (s == 31 && act) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_queue_empty: got word %h expected none pending", wrd);
          end else begin
            e = exp_q.pop_front();
            chk("channel_word", {16'h0000, wrd}, {16'h0000, e});
          end
          chk("pad_zero", {31'd0, pad}, 32'd0);
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int rsnap;
    int usnap;
    logic quiet;
    rst        = 1'b1;
    enable     = 1'b0;
    play_valid = 1'b0;
    play_data  = 16'h0000;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", {29'd0, aud_dacdat, request_play_data, underrun}, 32'd0);
    end
    rst = 1'b0;

    quiet = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      quiet = quiet | aud_dacdat | request_play_data | underrun;
    end
    chk("idle_quiet", {31'd0, quiet}, 32'd0);

    // Enable in the middle of a right half; ARM waits for the next LRCK fall.
    wait_frame();
    step(640);
    enable = 1'b1;
    wait_frame();
    mon_on = 1'b1;

    run_frame(1'b1, 16'hA5C3,   4, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 0); // prime
    run_frame(1'b1, 16'h1234,   4, 1'b0, 16'h0000, 1'b0, 16'hA5C3, 1, 0);
    run_frame(1'b0, 16'h0000,   0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1, 0); // withheld
    run_frame(1'b1, 16'h5555, 200, 1'b0, 16'h0000, 1'b0, UND_WORD, 1, 1); // late
    run_frame(1'b1, 16'h0F0F,   4, 1'b0, 16'h0000, 1'b1, 16'h5555, 1, 0); // unsolicited
    run_frame(1'b1, 16'hA5C3,   4, 1'b0, 16'h0000, 1'b0, 16'h0F0F, 1, 0);

    // Abort in the middle of the left word (0xA5C3, 8th bit is 1).
    mon_on = 1'b0;
    rsnap  = req_cnt;
    usnap  = und_cnt;
    step(140);
    chk("abort_mid_word_bit", {31'd0, aud_dacdat}, 32'd1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_next_cycle", {31'd0, aud_dacdat}, 32'd0);
    quiet = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      quiet = quiet | aud_dacdat | request_play_data | underrun;
    end
    chk("abort_quiet", {31'd0, quiet}, 32'd0);
    enable = 1'b1;
    wait_frame();
    chk("abort_frame_req", req_cnt - rsnap, 32'd1);
    chk("abort_frame_underrun", und_cnt - usnap, 32'd0);
    mon_on = 1'b1;

    run_frame(1'b0, 16'h0000,   0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 0); // re-prime
    run_frame(1'b1, 16'hA5C3,   4, 1'b1, 16'h8001, 1'b0, 16'h8001, 1, 0); // coincident
    run_frame(1'b0, 16'h0000,   0, 1'b0, 16'h0000, 1'b0, 16'hA5C3, 1, 0);

    step(10);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
